cv32e40p_rr_arbiter: RTL

CV32E40P_RR_ARBITER -- requirements
Module: cv32e40p_rr_arbiter

---
 rtl/cv32e40p_rr_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/cv32e40p_rr_arbiter.sv
// Round-robin arbiter with registered one-hot grant and valid/ready handshake.
// Optional grant lock across handshakes: define CV32E40P_RR_ARB_LOCK_EN.

module cv32e40p_ff_one #(
  parameter int LEN = 32
) (
  input  logic [LEN-1:0]         in_i,
  output logic [$clog2(LEN)-1:0] first_one_o,
  output logic                   no_ones_o
);
  localparam int W = $clog2(LEN);

  // Scan downwards so the lowest set bit is the last one written.
  always_comb begin
    first_one_o = '0;
    no_ones_o   = 1'b1;
    for (int i = LEN - 1; i >= 0; i--) begin
      if (in_i[i]) begin
        first_one_o = W'(i);
        no_ones_o   = 1'b0;
      end
    end
  end
endmodule

module cv32e40p_rr_arbiter #(
  parameter int NUM_REQ = 8,
  localparam int IDX_W = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               ready_i,
`ifdef CV32E40P_RR_ARB_LOCK_EN
  input  logic               lock_i,
`endif
  output logic               valid_o,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   gnt_idx_o
);
  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               init_q;
  logic               lock;
  logic [NUM_REQ-1:0] others;
  logic [NUM_REQ-1:0] srch;
  logic [NUM_REQ-1:0] mask;
  logic [IDX_W-1:0]   base;
  logic [IDX_W-1:0]   win_m, win_u, win;
  logic               none_m, none_u;

`ifdef CV32E40P_RR_ARB_LOCK_EN
  assign lock = lock_i;
`else
  assign lock = 1'b0;
`endif

  // While granting, the next winner is searched from the current grant.
  assign others = req_i & ~(NUM_REQ'(1) << idx_q);
  assign srch   = (state_q == GRANT) ? others : req_i;
  assign base   = (state_q == GRANT) ? idx_q : ptr_q;

  always_comb begin
    mask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      mask[i] = (i > int'(base));
    end
  end

  cv32e40p_ff_one #(.LEN(NUM_REQ)) u_ff_masked (
    .in_i        (srch & mask),
    .first_one_o (win_m),
    .no_ones_o   (none_m)
  );

  cv32e40p_ff_one #(.LEN(NUM_REQ)) u_ff_unmasked (
    .in_i        (srch),
    .first_one_o (win_u),
    .no_ones_o   (none_u)
  );

  assign win = none_m ? win_u : win_m;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (init_q && !none_u) begin
          state_d = GRANT;
          idx_d   = win;
        end
      end
      GRANT: begin
        if (!req_i[idx_q]) begin
          state_d = IDLE;
        end else if (ready_i && !lock) begin
          ptr_d = idx_q;
          if (|others) begin
            idx_d = win;
          end else begin
            state_d = IDLE;
          end
        end
      end
    endcase
  end

  // init_q delays the first grant to the second edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= IDX_W'(NUM_REQ - 1);
      idx_q   <= '0;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      init_q  <= 1'b1;
    end
  end

  assign valid_o   = (state_q == GRANT);
  assign gnt_o     = valid_o ? (NUM_REQ'(1) << idx_q) : '0;
  assign gnt_idx_o = valid_o ? idx_q : '0;
endmodule
